// File: rtl/mult_pkg.sv
// Shared types and default sizing for the multiplier arbiter slice.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after the
// pointer, wrapping, returned as a one-hot grant plus its index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx
);

  logic           w_found;
  logic [IDW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDW'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        w_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier engine among NUM_REQ requesters with
// round-robin arbitration, a completion watchdog and a held, acknowledged response.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_x,
  input  logic [NUM_REQ*WIDTH-1:0]   req_y,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [2*WIDTH-1:0]         resp_product,
  output logic                       resp_err,
  input  logic                       resp_ack,
  output logic                       eng_start,
  output logic [WIDTH-1:0]           eng_x,
  output logic [WIDTH-1:0]           eng_y,
  input  logic                       eng_ready,
  input  logic [2*WIDTH-1:0]         eng_product
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT) + 1;

  arb_state_t         r_state;
  arb_state_t         w_nextState;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_id;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_err;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_gidx;
  logic [CW-1:0]      w_cntNext;
  logic               w_timeout;
  logic               w_accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx)
  );

  // Watchdog compares the post-increment count so the error response lands
  // TIMEOUT cycles after the start pulse.
  assign w_cntNext = r_cnt + CW'(1);
  assign w_timeout = (w_cntNext == CW'(TIMEOUT - 1));
  assign w_accept  = (r_state == IDLE) && rst_in && (|req_valid);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_prod  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id <= w_gidx;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (w_grant[i]) begin
                r_x <= req_x[i*WIDTH +: WIDTH];
                r_y <= req_y[i*WIDTH +: WIDTH];
              end
            end
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          r_cnt <= w_cntNext;
          if (eng_ready) begin
            r_prod <= eng_product;
            r_err  <= 1'b0;
          end else if (w_timeout) begin
            r_prod <= '0;
            r_err  <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ack) begin
            r_ptr <= (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + IDW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_nextState  = r_state;
    req_ready    = '0;
    eng_start    = 1'b0;
    eng_x        = '0;
    eng_y        = '0;
    resp_valid   = 1'b0;
    resp_id      = '0;
    resp_product = '0;
    resp_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          req_ready   = w_grant;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        eng_start   = 1'b1;
        eng_x       = r_x;
        eng_y       = r_y;
        w_nextState = WAIT;
      end
      WAIT: begin
        eng_x = r_x;
        eng_y = r_y;
        if (eng_ready || w_timeout) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        eng_x        = r_x;
        eng_y        = r_y;
        resp_valid   = 1'b1;
        resp_id      = r_id;
        resp_product = r_prod;
        resp_err     = r_err;
        if (resp_ack) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a fixed-latency engine model.
module tb_mult_arbiter;

  logic        clk_in;
  logic        rst_in;
  logic [3:0]  req_valid;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [7:0]  resp_product;
  logic        resp_err;
  logic        resp_ack;
  logic        eng_start;
  logic [3:0]  eng_x;
  logic [3:0]  eng_y;
  logic        eng_ready;
  logic [7:0]  eng_product;

  logic        engEnable;
  int          engCnt;
  int          nChecks;
  int          nFails;
  logic [24:0] allOut;

  mult_arbiter #(
    .NUM_REQ (4),
    .WIDTH   (4),
    .TIMEOUT (16)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .req_valid    (req_valid),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .resp_err     (resp_err),
    .resp_ack     (resp_ack),
    .eng_start    (eng_start),
    .eng_x        (eng_x),
    .eng_y        (eng_y),
    .eng_ready    (eng_ready),
    .eng_product  (eng_product)
  );

  assign allOut = {req_ready, resp_valid, resp_id, resp_product, resp_err, eng_start, eng_x, eng_y};

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Engine model: eng_ready pulses five cycles after the start cycle.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      engCnt      <= 0;
      eng_ready   <= 1'b0;
      eng_product <= 8'd0;
    end else begin
      eng_ready <= 1'b0;
      if (eng_start && engEnable) begin
        engCnt      <= 4;
        eng_product <= 8'(eng_x) * 8'(eng_y);
      end else if (engCnt == 1) begin
        engCnt    <= 0;
        eng_ready <= 1'b1;
      end else if (engCnt > 1) begin
        engCnt <= engCnt - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic waitResp(input int limit, output int n);
    n = 0;
    while (resp_valid !== 1'b1 && n < limit) begin
      tick();
      #1;
      n++;
    end
  endtask

  task automatic doAck();
    resp_ack = 1'b1;
    tick();
    resp_ack = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_in    = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      nChecks++;
      if (allOut !== 25'd0) begin
        nFails++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %h expected 0", c, allOut);
      end
    end
    req_valid = 4'b0000;
    rst_in    = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    req_x[3:0] = 4'd3;
    req_y[3:0] = 4'd5;
    req_valid  = 4'b0001;
    #1;
    nChecks++;
    if (req_ready !== 4'b0001 || eng_start !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL single_grant: ready=%b start=%b expected ready=0001 start=0", req_ready, eng_start);
    end
    tick();
    req_valid = 4'b0000;
    #1;
    nChecks++;
    if (eng_start !== 1'b1 || eng_x !== 4'd3 || eng_y !== 4'd5 || req_ready !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL single_start: start=%b x=%0d y=%0d ready=%b expected 1,3,5,0000",
               eng_start, eng_x, eng_y, req_ready);
    end
    tick();
    #1;
    nChecks++;
    if (eng_start !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL single_start_pulse: start=%b expected 0", eng_start);
    end
    waitResp(20, n);
    nChecks++;
    if (resp_valid !== 1'b1 || n !== 5) begin
      nFails++;
      $display("[TB] FAIL single_latency: valid=%b cycles after start=%0d expected 1 and 6", resp_valid, n + 1);
    end
    nChecks++;
    if (resp_id !== 2'd0 || resp_product !== 8'd15 || resp_err !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL single_resp: id=%0d prod=%0d err=%b expected 0,15,0", resp_id, resp_product, resp_err);
    end
    doAck();
    nChecks++;
    if (resp_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL single_ack_release: valid=%b expected 0", resp_valid);
    end
  endtask

  task automatic test_fairness();
    int n;
    logic [7:0] expProd [4] = '{8'd2, 8'd4, 8'd6, 8'd8};
    for (int i = 0; i < 4; i++) begin
      req_x[i*4 +: 4] = 4'(i + 1);
      req_y[i*4 +: 4] = 4'd2;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      nChecks++;
      if (req_ready !== 4'(1 << k)) begin
        nFails++;
        $display("[TB] FAIL fair_grant step %0d: got %b expected %b", k, req_ready, 4'(1 << k));
      end
      tick();
      req_valid[k] = 1'b0;
      waitResp(20, n);
      nChecks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(k) || resp_product !== expProd[k]) begin
        nFails++;
        $display("[TB] FAIL fair_resp step %0d: valid=%b id=%0d prod=%0d expected 1,%0d,%0d",
                 k, resp_valid, resp_id, resp_product, k, expProd[k]);
      end
      doAck();
    end
    // Serve requester 1 alone so the pointer lands on 2.
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = 4'b0000;
    waitResp(20, n);
    doAck();
    req_valid = 4'b0101;
    #1;
    nChecks++;
    if (req_ready !== 4'b0100) begin
      nFails++;
      $display("[TB] FAIL fair_skip: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = 4'b0001;
    waitResp(20, n);
    nChecks++;
    if (resp_id !== 2'd2 || resp_product !== 8'd6) begin
      nFails++;
      $display("[TB] FAIL fair_skip_resp: id=%0d prod=%0d expected 2,6", resp_id, resp_product);
    end
    doAck();
    #1;
    nChecks++;
    if (req_ready !== 4'b0001) begin
      nFails++;
      $display("[TB] FAIL fair_wrap: got %b expected 0001", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    waitResp(20, n);
    doAck();
  endtask

  task automatic test_timeout();
    int n;
    engEnable  = 1'b0;
    req_x[3:0] = 4'd7;
    req_y[3:0] = 4'd7;
    req_valid  = 4'b0001;
    tick();
    req_valid = 4'b0000;
    #1;
    nChecks++;
    if (eng_start !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL timeout_start: got %b expected 1", eng_start);
    end
    waitResp(40, n);
    nChecks++;
    if (resp_valid !== 1'b1 || n !== 16) begin
      nFails++;
      $display("[TB] FAIL timeout_latency: valid=%b cycles=%0d expected 1 and 16", resp_valid, n);
    end
    nChecks++;
    if (resp_err !== 1'b1 || resp_product !== 8'd0 || resp_id !== 2'd0) begin
      nFails++;
      $display("[TB] FAIL timeout_resp: err=%b prod=%0d id=%0d expected 1,0,0", resp_err, resp_product, resp_id);
    end
    engEnable = 1'b1;
    doAck();
  endtask

  task automatic test_backpressure();
    int n;
    req_x[3:0] = 4'd9;
    req_y[3:0] = 4'd3;
    req_valid  = 4'b0001;
    tick();
    req_valid = 4'b0000;
    waitResp(20, n);
    req_x[7:4] = 4'd2;
    req_y[7:4] = 4'd2;
    req_valid  = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      #1;
      nChecks++;
      if ({resp_valid, resp_id, resp_product, resp_err, req_ready, eng_start} !== {1'b1, 2'd0, 8'd27, 1'b0, 4'b0000, 1'b0}) begin
        nFails++;
        $display("[TB] FAIL backpressure cycle %0d: valid=%b id=%0d prod=%0d err=%b ready=%b start=%b expected 1,0,27,0,0000,0",
                 c, resp_valid, resp_id, resp_product, resp_err, req_ready, eng_start);
      end
      tick();
    end
    doAck();
    nChecks++;
    if (req_ready !== 4'b0010) begin
      nFails++;
      $display("[TB] FAIL backpressure_next_grant: got %b expected 0010", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    waitResp(20, n);
    nChecks++;
    if (resp_id !== 2'd1 || resp_product !== 8'd4) begin
      nFails++;
      $display("[TB] FAIL backpressure_second: id=%0d prod=%0d expected 1,4", resp_id, resp_product);
    end
    doAck();
  endtask

  task automatic test_abort();
    int n;
    req_x[15:12] = 4'd15;
    req_y[15:12] = 4'd15;
    req_valid    = 4'b1000;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    rst_in = 1'b0;
    #1;
    nChecks++;
    if (allOut !== 25'd0) begin
      nFails++;
      $display("[TB] FAIL abort_outputs: got %h expected 0", allOut);
    end
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    #1;
    nChecks++;
    if (resp_valid !== 1'b0 || eng_start !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL abort_no_resp: valid=%b start=%b expected 0,0", resp_valid, eng_start);
    end
    req_valid = 4'b1000;
    #1;
    nChecks++;
    if (req_ready !== 4'b1000) begin
      nFails++;
      $display("[TB] FAIL abort_regrant: got %b expected 1000", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    waitResp(20, n);
    nChecks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_product !== 8'd225 || resp_err !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL abort_resp: valid=%b id=%0d prod=%0d err=%b expected 1,3,225,0",
               resp_valid, resp_id, resp_product, resp_err);
    end
    doAck();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nChecks   = 0;
    nFails    = 0;
    rst_in    = 1'b0;
    req_valid = 4'b0000;
    req_x     = 16'd0;
    req_y     = 16'd0;
    resp_ack  = 1'b0;
    engEnable = 1'b1;
    test_reset();
    test_fairness();
    test_single();
    test_timeout();
    test_backpressure();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
